branch_predictor_gshare: RTL and testbench

Parametrised decode-stage branch predictor for the 5-stage RV32I pipeline. It replaces the fixed 2-bit bimodal BHT with a gshare-indexed table of CTR_BITS-wide saturating counters. It adds a speculative global history register with mispredict repair, a circular return-address stack (RAS) for JAL/JALR call/return, and hit/branch statistics counters. Queried combinationally by decode and updated by execute.

---
 rtl/branch_predictor_gshare.sv | 138 +++++++++++++
 tb/tb_branch_predictor_gshare.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor_gshare.sv
// Decode-stage branch predictor: gshare/bimodal counter table, speculative global
// history with mispredict repair, circular return-address stack and hit statistics.
module branch_predictor_gshare #(
  parameter int BHT_ADDR_BITS = 5,
  parameter int GHR_BITS      = 4,
  parameter int GSHARE        = 1,
  parameter int CTR_BITS      = 2,
  parameter int RAS_DEPTH     = 4
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     q_valid,
  input  logic                     q_stall,
  input  logic [31:0]              q_pc,
  input  logic [31:0]              q_instr,
  output logic                     p_taken,
  output logic [31:0]              p_target,
  output logic [BHT_ADDR_BITS-1:0] p_index,
  output logic [GHR_BITS-1:0]      p_ghr,
  input  logic                     u_valid,
  input  logic                     u_taken,
  input  logic                     u_predicted,
  input  logic [BHT_ADDR_BITS-1:0] u_index,
  input  logic [GHR_BITS-1:0]      u_ghr,
  output logic [31:0]              stat_branches,
  output logic [31:0]              stat_hits
);

  localparam int BHT_ENTRIES = 1 << BHT_ADDR_BITS;
  localparam int RAS_PTR_W   = $clog2(RAS_DEPTH);
  localparam int RAS_CNT_W   = $clog2(RAS_DEPTH + 1);
  localparam logic [CTR_BITS-1:0]  CTR_INIT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
  localparam logic [CTR_BITS-1:0]  CTR_MAX  = '1;
  localparam logic [RAS_CNT_W-1:0] RAS_FULL = RAS_CNT_W'(RAS_DEPTH);

  // Protocol: the query side is a pure combinational lookup that may repeat while
  // q_stall=1; speculative state advances once per accepted instruction (q_fire).
  // The update side has no backpressure: every u_valid cycle is consumed.
  logic [CTR_BITS-1:0]      bht [BHT_ENTRIES];
  logic [GHR_BITS-1:0]      ghr;
  logic [31:0]              ras [RAS_DEPTH];
  logic [RAS_PTR_W-1:0]     ras_ptr;
  logic [RAS_CNT_W-1:0]     ras_count;

  logic [6:0]  opcode;
  logic [4:0]  rd, rs1;
  logic        is_b, is_jal, is_jalr, rd_link, rs1_link, is_call, is_ret;
  logic [31:0] b_imm, j_imm, link_addr;
  logic [BHT_ADDR_BITS-1:0] index;
  logic                     pred_bit;
  logic [RAS_PTR_W-1:0]     ras_top_ptr;
  logic                     ras_nonempty, q_fire, do_push, do_pop, mispredict;

  assign opcode   = q_instr[6:0];
  assign rd       = q_instr[11:7];
  assign rs1      = q_instr[19:15];
  assign is_b     = (opcode == 7'b1100011);
  assign is_jal   = (opcode == 7'b1101111);
  assign is_jalr  = (opcode == 7'b1100111);
  assign rd_link  = (rd == 5'd1) || (rd == 5'd5);
  assign rs1_link = (rs1 == 5'd1) || (rs1 == 5'd5);
  assign is_call  = (is_jal || is_jalr) && rd_link;
  assign is_ret   = is_jalr && rs1_link && (rd == 5'd0);

  assign b_imm = {{19{q_instr[31]}}, q_instr[31], q_instr[7], q_instr[30:25], q_instr[11:8], 1'b0};
  assign j_imm = {{11{q_instr[31]}}, q_instr[31], q_instr[19:12], q_instr[20], q_instr[30:21], 1'b0};
  assign link_addr = q_pc + 32'd4;

  assign index = (GSHARE != 0) ? (q_pc[BHT_ADDR_BITS+1:2] ^ BHT_ADDR_BITS'(ghr))
                               : q_pc[BHT_ADDR_BITS+1:2];
  assign pred_bit     = bht[index][CTR_BITS-1];
  assign ras_top_ptr  = ras_ptr - RAS_PTR_W'(1);
  assign ras_nonempty = (ras_count != '0);

  assign q_fire     = q_valid && !q_stall;
  assign do_push    = q_fire && is_call;
  assign do_pop     = q_fire && is_ret && ras_nonempty;
  assign mispredict = u_valid && (u_taken != u_predicted);

  assign p_taken = q_valid && (is_jal || (is_b && pred_bit) || (is_ret && ras_nonempty));
  assign p_index = index;
  assign p_ghr   = ghr;

  always_comb begin
    p_target = link_addr;
    if (is_jal)      p_target = q_pc + j_imm;
    else if (is_b)   p_target = q_pc + b_imm;
    else if (is_ret) p_target = ras[ras_top_ptr];
  end

  // Repair wins over a same-cycle shift: the instruction in decode is on the wrong path.
  always_ff @(posedge clk) begin
    if (!resetn)                ghr <= '0;
    else if (mispredict)        ghr <= GHR_BITS'({u_ghr, u_taken});
    else if (q_fire && is_b)    ghr <= GHR_BITS'({ghr, pred_bit});
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= CTR_INIT;
    end else if (u_valid) begin
      if (u_taken && (bht[u_index] != CTR_MAX))
        bht[u_index] <= bht[u_index] + CTR_BITS'(1);
      else if (!u_taken && (bht[u_index] != '0))
        bht[u_index] <= bht[u_index] - CTR_BITS'(1);
    end
  end

  // Circular stack: ras_ptr is the next free slot, so a push on a full stack
  // overwrites the oldest entry. A combined pop+push just replaces the top.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < RAS_DEPTH; i++) ras[i] <= '0;
      ras_ptr   <= '0;
      ras_count <= '0;
    end else if (do_push && do_pop) begin
      ras[ras_top_ptr] <= link_addr;
    end else if (do_push) begin
      ras[ras_ptr] <= link_addr;
      ras_ptr      <= ras_ptr + RAS_PTR_W'(1);
      if (ras_count != RAS_FULL) ras_count <= ras_count + RAS_CNT_W'(1);
    end else if (do_pop) begin
      ras_ptr   <= ras_top_ptr;
      ras_count <= ras_count - RAS_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      stat_branches <= '0;
      stat_hits     <= '0;
    end else if (u_valid) begin
      stat_branches <= stat_branches + 32'd1;
      if (u_taken == u_predicted) stat_hits <= stat_hits + 32'd1;
    end
  end

endmodule

// File: tb/tb_branch_predictor_gshare.sv
// Bench for branch_predictor_gshare: queue-based reference model checked every
// cycle, plus directed vectors with hand-computed literal expectations.
module tb_branch_predictor_gshare;

  localparam int BA = 5, GB = 4, GS = 1, CB = 2, RD = 4;
  localparam int N = 1 << BA;
  localparam int GMASK = (1 << GB) - 1;

  localparam logic [31:0] BEQ_16   = 32'h0000_0863; // beq x0,x0,+16
  localparam logic [31:0] JAL_X1   = 32'h0200_00EF; // jal x1,+0x20
  localparam logic [31:0] RET_X1   = 32'h0000_8067; // jalr x0,0(x1)
  localparam logic [31:0] CALL_X5  = 32'h0081_02E7; // jalr x5,8(x2)
  localparam logic [31:0] RET_X5   = 32'h0002_8067; // jalr x0,0(x5)
  localparam logic [31:0] ADDI_NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic resetn;
  logic q_valid, q_stall;
  logic [31:0] q_pc, q_instr;
  logic p_taken;
  logic [31:0] p_target;
  logic [BA-1:0] p_index;
  logic [GB-1:0] p_ghr;
  logic u_valid, u_taken, u_predicted;
  logic [BA-1:0] u_index;
  logic [GB-1:0] u_ghr;
  logic [31:0] stat_branches, stat_hits;

  branch_predictor_gshare #(
    .BHT_ADDR_BITS(BA), .GHR_BITS(GB), .GSHARE(GS), .CTR_BITS(CB), .RAS_DEPTH(RD)
  ) dut (
    .clk(clk), .resetn(resetn),
    .q_valid(q_valid), .q_stall(q_stall), .q_pc(q_pc), .q_instr(q_instr),
    .p_taken(p_taken), .p_target(p_target), .p_index(p_index), .p_ghr(p_ghr),
    .u_valid(u_valid), .u_taken(u_taken), .u_predicted(u_predicted),
    .u_index(u_index), .u_ghr(u_ghr),
    .stat_branches(stat_branches), .stat_hits(stat_hits)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model
  int          m_ctr [N];
  int          m_ghr;
  logic [31:0] m_ras [$];
  logic [31:0] m_branches, m_hits;
  bit          model_live = 0;

  function automatic bit is_link(input logic [4:0] r);
    return (r == 5'd1) || (r == 5'd5);
  endfunction

  function automatic void classify(input logic [31:0] i, output bit b, output bit jal,
                                   output bit call, output bit ret);
    bit jalr;
    b    = (i[6:0] == 7'b1100011);
    jal  = (i[6:0] == 7'b1101111);
    jalr = (i[6:0] == 7'b1100111);
    call = (jal || jalr) && is_link(i[11:7]);
    ret  = jalr && is_link(i[19:15]) && (i[11:7] == 5'd0);
  endfunction

  function automatic int bimm(input logic [31:0] i);
    int v;
    v = (int'(i[31]) << 12) | (int'(i[7]) << 11) | (int'(i[30:25]) << 5) | (int'(i[11:8]) << 1);
    if (v >= 4096) v -= 8192;
    return v;
  endfunction

  function automatic int jimm(input logic [31:0] i);
    int v;
    v = (int'(i[31]) << 20) | (int'(i[19:12]) << 12) | (int'(i[20]) << 11) | (int'(i[30:21]) << 1);
    if (v >= (1 << 20)) v -= (1 << 21);
    return v;
  endfunction

  function automatic int m_index(input logic [31:0] pc);
    int h;
    h = (GS != 0) ? m_ghr : 0;
    return (int'(pc >> 2) ^ h) & (N - 1);
  endfunction

  always @(posedge clk) begin
    bit b, jal, call, ret, pred, fire;
    int idx;
    if (!resetn) begin
      for (int i = 0; i < N; i++) m_ctr[i] = (1 << (CB - 1)) - 1;
      m_ghr = 0;
      m_ras.delete();
      m_branches = 0;
      m_hits = 0;
      model_live = 1;
    end else if (model_live) begin
      classify(q_instr, b, jal, call, ret);
      idx  = m_index(q_pc);
      pred = m_ctr[idx] >= (1 << (CB - 1));
      fire = q_valid && !q_stall;
      if (u_valid && (u_taken != u_predicted)) m_ghr = ((int'(u_ghr) << 1) | int'(u_taken)) & GMASK;
      else if (fire && b) m_ghr = ((m_ghr << 1) | int'(pred)) & GMASK;
      if (fire) begin
        if (ret && m_ras.size() > 0) void'(m_ras.pop_back());
        if (call) begin
          m_ras.push_back(q_pc + 32'd4);
          if (m_ras.size() > RD) void'(m_ras.pop_front());
        end
      end
      if (u_valid) begin
        if (u_taken && m_ctr[u_index] < (1 << CB) - 1) m_ctr[u_index]++;
        if (!u_taken && m_ctr[u_index] > 0) m_ctr[u_index]--;
        m_branches++;
        if (u_taken == u_predicted) m_hits++;
      end
    end
  end

  // compare process: outputs checked against the model every cycle once reset has been seen
  always @(negedge clk) begin
    bit b, jal, call, ret, e_taken;
    int idx;
    logic [31:0] e_target;
    if (model_live) begin
      classify(q_instr, b, jal, call, ret);
      idx = m_index(q_pc);
      e_taken = q_valid && (jal || (b && m_ctr[idx] >= (1 << (CB - 1))) || (ret && m_ras.size() > 0));
      if (jal)      e_target = q_pc + 32'(jimm(q_instr));
      else if (b)   e_target = q_pc + 32'(bimm(q_instr));
      else if (ret) e_target = (m_ras.size() > 0) ? m_ras[$] : p_target;
      else          e_target = q_pc + 32'd4;
      check("m_p_taken", 32'(p_taken), 32'(e_taken));
      if (!(ret && m_ras.size() == 0)) check("m_p_target", p_target, e_target);
      check("m_p_index", 32'(p_index), 32'(idx));
      check("m_p_ghr", 32'(p_ghr), 32'(m_ghr));
      check("m_stat_branches", stat_branches, m_branches);
      check("m_stat_hits", stat_hits, m_hits);
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive_q(input logic valid, input logic stall, input logic [31:0] pc,
                         input logic [31:0] instr);
    q_valid = valid;
    q_stall = stall;
    q_pc    = pc;
    q_instr = instr;
  endtask

  task automatic upd(input logic taken, input logic predicted, input logic [BA-1:0] idx,
                     input logic [GB-1:0] ghr);
    u_valid     = 1'b1;
    u_taken     = taken;
    u_predicted = predicted;
    u_index     = idx;
    u_ghr       = ghr;
    tick();
    u_valid     = 1'b0;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
  endtask

  logic [31:0] ret_exp [4];

  initial begin
    resetn = 1'b0;
    drive_q(1'b0, 1'b0, 32'h0, 32'h0);
    u_valid = 1'b0; u_taken = 1'b0; u_predicted = 1'b0; u_index = '0; u_ghr = '0;
    tick();
    tick();
    resetn = 1'b1;

    // reset state seen through a BEQ at 0x40
    drive_q(1'b1, 1'b1, 32'h40, BEQ_16);
    settle();
    check("rst_p_taken", 32'(p_taken), 32'd0);
    check("rst_p_target", p_target, 32'h50);
    check("rst_p_index", 32'(p_index), 32'd16);
    check("rst_p_ghr", 32'(p_ghr), 32'd0);
    check("rst_stat_branches", stat_branches, 32'd0);
    check("rst_stat_hits", stat_hits, 32'd0);

    // counter saturation at index 16 (query held by stall)
    repeat (2) upd(1'b1, 1'b1, 5'd16, 4'd0);
    check("ctr_11_taken", 32'(p_taken), 32'd1);
    repeat (4) upd(1'b1, 1'b1, 5'd16, 4'd0);
    upd(1'b0, 1'b0, 5'd16, 4'd0);
    check("ctr_sat_hi_taken", 32'(p_taken), 32'd1);
    upd(1'b1, 1'b1, 5'd16, 4'd0);
    repeat (4) upd(1'b0, 1'b0, 5'd16, 4'd0);
    check("ctr_00_not_taken", 32'(p_taken), 32'd0);
    repeat (2) upd(1'b1, 1'b1, 5'd16, 4'd0);
    check("ctr_sat_lo_taken", 32'(p_taken), 32'd1);
    check("stat_branches_14", stat_branches, 32'd14);
    check("stat_hits_14", stat_hits, 32'd14);

    // speculative history and repair
    do_reset();
    drive_q(1'b0, 1'b0, 32'h40, BEQ_16);
    repeat (2) upd(1'b1, 1'b1, 5'd16, 4'd0);
    repeat (2) upd(1'b1, 1'b1, 5'd17, 4'd0);
    repeat (2) upd(1'b1, 1'b1, 5'd19, 4'd0);
    drive_q(1'b1, 1'b0, 32'h40, BEQ_16);
    settle();
    check("ghr_0_taken", 32'(p_taken), 32'd1);
    tick();
    check("ghr_1", 32'(p_ghr), 32'b0001);
    check("ghr_1_taken", 32'(p_taken), 32'd1);
    tick();
    check("ghr_3", 32'(p_ghr), 32'b0011);
    check("ghr_3_taken", 32'(p_taken), 32'd1);
    tick();
    check("ghr_7", 32'(p_ghr), 32'b0111);
    upd(1'b0, 1'b1, 5'd5, 4'b0010);
    check("ghr_repair", 32'(p_ghr), 32'b0100);
    check("ghr_stat_branches", stat_branches, 32'd7);
    check("ghr_stat_hits", stat_hits, 32'd6);

    // call / return
    drive_q(1'b1, 1'b0, 32'h100, JAL_X1);
    settle();
    check("jal_taken", 32'(p_taken), 32'd1);
    check("jal_target", p_target, 32'h120);
    tick();
    drive_q(1'b1, 1'b0, 32'h120, RET_X1);
    settle();
    check("ret_taken", 32'(p_taken), 32'd1);
    check("ret_target", p_target, 32'h104);
    tick();
    drive_q(1'b1, 1'b0, 32'h124, RET_X1);
    settle();
    check("ret_empty_not_taken", 32'(p_taken), 32'd0);
    tick();

    // overflow: five calls into a four-entry stack
    for (int k = 1; k <= 5; k++) begin
      drive_q(1'b1, 1'b0, 32'(k * 16), JAL_X1);
      tick();
    end
    ret_exp[0] = 32'h54; ret_exp[1] = 32'h44; ret_exp[2] = 32'h34; ret_exp[3] = 32'h24;
    for (int k = 0; k < 4; k++) begin
      drive_q(1'b1, 1'b0, 32'h200, RET_X1);
      settle();
      check("ovf_ret_taken", 32'(p_taken), 32'd1);
      check("ovf_ret_target", p_target, ret_exp[k]);
      tick();
    end
    settle();
    check("ovf_5th_ret_not_taken", 32'(p_taken), 32'd0);
    tick();

    // x5 as link, non-control instruction
    drive_q(1'b1, 1'b0, 32'h500, CALL_X5);
    settle();
    check("jalr_call_not_taken", 32'(p_taken), 32'd0);
    check("jalr_call_target", p_target, 32'h504);
    tick();
    drive_q(1'b1, 1'b0, 32'h600, RET_X5);
    settle();
    check("ret_x5_target", p_target, 32'h504);
    tick();
    drive_q(1'b1, 1'b0, 32'h700, ADDI_NOP);
    settle();
    check("addi_not_taken", 32'(p_taken), 32'd0);
    check("addi_target", p_target, 32'h704);
    tick();

    // stalled call pushes once
    drive_q(1'b1, 1'b1, 32'h300, JAL_X1);
    repeat (3) tick();
    q_stall = 1'b0;
    tick();
    drive_q(1'b1, 1'b1, 32'h400, RET_X1);
    settle();
    check("stall_ret_taken", 32'(p_taken), 32'd1);
    check("stall_ret_target", p_target, 32'h304);
    tick();
    q_stall = 1'b0;
    tick();
    settle();
    check("stall_single_push", 32'(p_taken), 32'd0);

    // mid-operation reset with a same-cycle update
    drive_q(1'b1, 1'b0, 32'h300, JAL_X1);
    tick();
    drive_q(1'b1, 1'b1, 32'h400, RET_X1);
    u_valid = 1'b1; u_taken = 1'b1; u_predicted = 1'b0; u_index = 5'd3; u_ghr = 4'b1111;
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    u_valid = 1'b0;
    settle();
    check("mid_rst_ret_not_taken", 32'(p_taken), 32'd0);
    check("mid_rst_ghr", 32'(p_ghr), 32'd0);
    check("mid_rst_stat_branches", stat_branches, 32'd0);
    check("mid_rst_stat_hits", stat_hits, 32'd0);
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
